controladora_mc: RTL and testbench

Parametrised multicycle control unit for the MIPS-subset datapath; successor of the first-generation controller. Sequences fetch/decode/execute/writeback per instruction, and adds several behaviours the first generation lacks:
- configurable memory wait states;
- a start/done handshake with the mult/div unit;
- precise exceptions (invalid opcode, overflow, divide-by-zero) with EPC/cause capture.

---
 rtl/controladora_mc.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_controladora_mc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controladora_mc.sv
// controladora_mc: multicycle control unit for the MIPS-subset datapath.
// Sequences fetch/decode/execute/writeback with memory wait states,
// a mult/div start/done handshake and precise exceptions (EPC/cause).
// Params: MEM_LAT (1..15 cycles per memory access), EXC_EN (overflow traps).
// In : clk, reset (sync, active-high), opcode, funct, overflow, zero,
//      md_done, md_div0.
// Out: datapath write enables, mux selects, alu_op, md_start/md_op,
//      cause, state_dbg.
module controladora_mc #(
   parameter int MEM_LAT = 1,
   parameter bit EXC_EN  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       overflow,
   input  logic       zero,
   input  logic       md_done,
   input  logic       md_div0,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_wr,
   output logic       reg_write,
   output logic       ab_load,
   output logic       alu_out_load,
   output logic       epc_write,
   output logic       cause_write,
   output logic       hilo_write,
   output logic       md_start,
   output logic       iord,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [2:0] pc_src,
   output logic [1:0] reg_dst,
   output logic [2:0] mem_to_reg,
   output logic       md_op,
   output logic [1:0] cause,
   output logic [4:0] state_dbg
);

   typedef enum logic [4:0] {
      S_FETCH     = 5'd0,
      S_DECODE    = 5'd1,
      S_R_EXEC    = 5'd2,
      S_R_WB      = 5'd3,
      S_ADDI_EXEC = 5'd4,
      S_ADDI_WB   = 5'd5,
      S_ADDR      = 5'd6,
      S_LW_MEM    = 5'd7,
      S_LW_WB     = 5'd8,
      S_SW_MEM    = 5'd9,
      S_BRANCH    = 5'd10,
      S_JUMP      = 5'd11,
      S_JR        = 5'd12,
      S_LUI       = 5'd13,
      S_MD_START  = 5'd14,
      S_MD_WAIT   = 5'd15,
      S_MD_WB     = 5'd16,
      S_MF        = 5'd17,
      S_EXC       = 5'd18
   } state_t;

   localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic [1:0] cause_q, cause_d;
   logic       md_op_q, md_op_d;

   logic mem_last;
   logic is_r;
   logic r_alu, r_jr, r_md, r_mf;
   logic op_addi, op_mem, op_br, op_j, op_lui;
   logic ovf_op;

   assign mem_last = (wait_q == LAST);
   assign is_r     = (opcode == 6'h00);
   assign r_alu    = is_r && (funct == 6'h20 || funct == 6'h22 ||
                              funct == 6'h24 || funct == 6'h25 ||
                              funct == 6'h2a);
   assign r_jr     = is_r && (funct == 6'h08);
   assign r_md     = is_r && (funct == 6'h18 || funct == 6'h1a);
   assign r_mf     = is_r && (funct == 6'h10 || funct == 6'h12);
   assign op_addi  = (opcode == 6'h08);
   assign op_mem   = (opcode == 6'h23 || opcode == 6'h2b);
   assign op_br    = (opcode == 6'h04 || opcode == 6'h05);
   assign op_j     = (opcode == 6'h02 || opcode == 6'h03);
   assign op_lui   = (opcode == 6'h0f);
   assign ovf_op   = (funct == 6'h20 || funct == 6'h22);

   // Next-state logic. The wait counter falls back to zero whenever a
   // memory state is left, so every memory state is entered with it clear.
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      cause_d = cause_q;
      md_op_d = md_op_q;
      case (state_q)
         S_FETCH: begin
            if (mem_last) state_d = S_DECODE;
            else          wait_d  = wait_q + 4'd1;
         end
         S_DECODE: begin
            unique case (1'b1)
               r_alu:   state_d = S_R_EXEC;
               r_jr:    state_d = S_JR;
               r_md: begin
                  state_d = S_MD_START;
                  md_op_d = funct[1];
               end
               r_mf:    state_d = S_MF;
               op_addi: state_d = S_ADDI_EXEC;
               op_mem:  state_d = S_ADDR;
               op_br:   state_d = S_BRANCH;
               op_j:    state_d = S_JUMP;
               op_lui:  state_d = S_LUI;
               default: begin
                  state_d = S_EXC;
                  cause_d = 2'd1;
               end
            endcase
         end
         S_R_EXEC: begin
            if (EXC_EN && ovf_op && overflow) begin
               state_d = S_EXC;
               cause_d = 2'd2;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_ADDI_EXEC: begin
            if (EXC_EN && overflow) begin
               state_d = S_EXC;
               cause_d = 2'd2;
            end else begin
               state_d = S_ADDI_WB;
            end
         end
         S_ADDR: begin
            state_d = (opcode == 6'h23) ? S_LW_MEM : S_SW_MEM;
         end
         S_LW_MEM: begin
            if (mem_last) state_d = S_LW_WB;
            else          wait_d  = wait_q + 4'd1;
         end
         S_SW_MEM: begin
            if (mem_last) state_d = S_FETCH;
            else          wait_d  = wait_q + 4'd1;
         end
         S_MD_START: state_d = S_MD_WAIT;
         S_MD_WAIT: begin
            if (md_done) begin
               if (md_div0) begin
                  state_d = S_EXC;
                  cause_d = 2'd3;
               end else begin
                  state_d = S_MD_WB;
               end
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         cause_q <= '0;
         md_op_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
         md_op_q <= md_op_d;
      end
   end

   // Moore decode of the current state; outputs are forced quiet while
   // reset is high so an aborted instruction issues no partial writes.
   always_comb begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_wr       = 1'b0;
      reg_write    = 1'b0;
      ab_load      = 1'b0;
      alu_out_load = 1'b0;
      epc_write    = 1'b0;
      cause_write  = 1'b0;
      hilo_write   = 1'b0;
      md_start     = 1'b0;
      iord         = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      alu_op       = 3'd0;
      pc_src       = 3'd0;
      reg_dst      = 2'd0;
      mem_to_reg   = 3'd0;
      md_op        = 1'b0;
      cause        = 2'd0;
      state_dbg    = state_q;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               if (mem_last) begin
                  ir_write  = 1'b1;
                  alu_src_b = 2'd1;
                  pc_write  = 1'b1;
               end
            end
            S_DECODE: begin
               ab_load      = 1'b1;
               alu_src_b    = 2'd3;
               alu_out_load = 1'b1;
            end
            S_R_EXEC: begin
               alu_src_a    = 1'b1;
               alu_out_load = 1'b1;
               case (funct)
                  6'h22:   alu_op = 3'd1;
                  6'h24:   alu_op = 3'd2;
                  6'h25:   alu_op = 3'd3;
                  6'h2a:   alu_op = 3'd4;
                  default: alu_op = 3'd0;
               endcase
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 2'd1;
            end
            S_ADDI_EXEC, S_ADDR: begin
               alu_src_a    = 1'b1;
               alu_src_b    = 2'd2;
               alu_out_load = 1'b1;
            end
            S_ADDI_WB, S_LUI: begin
               reg_write  = 1'b1;
               mem_to_reg = (state_q == S_LUI) ? 3'd5 : 3'd0;
            end
            S_LW_MEM: iord = 1'b1;
            S_LW_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 3'd1;
            end
            S_SW_MEM: begin
               iord   = 1'b1;
               mem_wr = 1'b1;
            end
            S_BRANCH: begin
               // beq takes the branch on zero, bne on not-zero
               alu_src_a = 1'b1;
               alu_op    = 3'd1;
               pc_src    = 3'd1;
               pc_write  = zero ^ opcode[0];
            end
            S_JUMP: begin
               pc_src   = 3'd2;
               pc_write = 1'b1;
               if (opcode[0]) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 3'd4;
               end
            end
            S_JR: begin
               pc_src   = 3'd3;
               pc_write = 1'b1;
            end
            S_MD_START: begin
               md_start = 1'b1;
               md_op    = md_op_q;
            end
            S_MD_WAIT: md_op = md_op_q;
            S_MD_WB:   hilo_write = 1'b1;
            S_MF: begin
               reg_write  = 1'b1;
               reg_dst    = 2'd1;
               mem_to_reg = funct[1] ? 3'd3 : 3'd2;
            end
            S_EXC: begin
               alu_src_b   = 2'd1;
               alu_op      = 3'd1;
               epc_write   = 1'b1;
               cause_write = 1'b1;
               cause       = cause_q;
               pc_src      = 3'd4;
               pc_write    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controladora_mc.sv
// tb_controladora_mc: directed bench for controladora_mc.
// Instance a: MEM_LAT=1, EXC_EN=1. Instance b: MEM_LAT=3, EXC_EN=0.
module tb_controladora_mc;

   logic       clk = 1'b0;
   logic       rst1, rst3;
   logic [5:0] opcode, funct;
   logic       overflow, zero, md_done, md_div0;

   logic       a_pc_write, a_ir_write, a_mem_wr, a_reg_write, a_ab_load;
   logic       a_alu_out_load, a_epc_write, a_cause_write, a_hilo_write;
   logic       a_md_start, a_iord, a_alu_src_a, a_md_op;
   logic [1:0] a_alu_src_b, a_reg_dst, a_cause;
   logic [2:0] a_alu_op, a_pc_src, a_mem_to_reg;
   logic [4:0] a_state;

   logic       b_pc_write, b_ir_write, b_mem_wr, b_reg_write, b_ab_load;
   logic       b_alu_out_load, b_epc_write, b_cause_write, b_hilo_write;
   logic       b_md_start, b_iord, b_alu_src_a, b_md_op;
   logic [1:0] b_alu_src_b, b_reg_dst, b_cause;
   logic [2:0] b_alu_op, b_pc_src, b_mem_to_reg;
   logic [4:0] b_state;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   controladora_mc #(.MEM_LAT(1), .EXC_EN(1'b1)) u_a (
      .clk(clk), .reset(rst1), .opcode(opcode), .funct(funct),
      .overflow(overflow), .zero(zero), .md_done(md_done),
      .md_div0(md_div0), .pc_write(a_pc_write), .ir_write(a_ir_write),
      .mem_wr(a_mem_wr), .reg_write(a_reg_write), .ab_load(a_ab_load),
      .alu_out_load(a_alu_out_load), .epc_write(a_epc_write),
      .cause_write(a_cause_write), .hilo_write(a_hilo_write),
      .md_start(a_md_start), .iord(a_iord), .alu_src_a(a_alu_src_a),
      .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .pc_src(a_pc_src),
      .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .md_op(a_md_op),
      .cause(a_cause), .state_dbg(a_state)
   );

   controladora_mc #(.MEM_LAT(3), .EXC_EN(1'b0)) u_b (
      .clk(clk), .reset(rst3), .opcode(opcode), .funct(funct),
      .overflow(overflow), .zero(zero), .md_done(md_done),
      .md_div0(md_div0), .pc_write(b_pc_write), .ir_write(b_ir_write),
      .mem_wr(b_mem_wr), .reg_write(b_reg_write), .ab_load(b_ab_load),
      .alu_out_load(b_alu_out_load), .epc_write(b_epc_write),
      .cause_write(b_cause_write), .hilo_write(b_hilo_write),
      .md_start(b_md_start), .iord(b_iord), .alu_src_a(b_alu_src_a),
      .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .pc_src(b_pc_src),
      .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .md_op(b_md_op),
      .cause(b_cause), .state_dbg(b_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst1 = 1'b1; rst3 = 1'b1;
      opcode = 6'h00; funct = 6'h00;
      overflow = 1'b0; zero = 1'b0; md_done = 1'b0; md_div0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state_a", a_state, 0);
      chk("rst_pcw_a", a_pc_write, 0);
      chk("rst_irw_a", a_ir_write, 0);
      chk("rst_cause_a", a_cause, 0);
      chk("rst_state_b", b_state, 0);

      // add, MEM_LAT=1
      funct = 6'h20; rst1 = 1'b0; #1;
      chk("add_c1_irw", a_ir_write, 1);
      chk("add_c1_pcw", a_pc_write, 1);
      chk("add_c1_srcb", a_alu_src_b, 1);
      step();
      chk("add_dec_state", a_state, 1);
      chk("add_dec_ab", a_ab_load, 1);
      chk("add_dec_srcb", a_alu_src_b, 3);
      chk("add_dec_aol", a_alu_out_load, 1);
      step();
      chk("add_ex_state", a_state, 2);
      chk("add_ex_srca", a_alu_src_a, 1);
      chk("add_ex_op", a_alu_op, 0);
      step();
      chk("add_wb_rw", a_reg_write, 1);
      chk("add_wb_dst", a_reg_dst, 1);
      chk("add_wb_m2r", a_mem_to_reg, 0);
      step();
      chk("add_back_fetch", a_state, 0);

      // add with overflow, EXC_EN=1
      step(); step();
      overflow = 1'b1; #1;
      chk("ovf_ex_rw", a_reg_write, 0);
      step();
      overflow = 1'b0;
      chk("ovf_exc_state", a_state, 18);
      chk("ovf_cause", a_cause, 2);
      chk("ovf_epcw", a_epc_write, 1);
      chk("ovf_causew", a_cause_write, 1);
      chk("ovf_pcsrc", a_pc_src, 4);
      chk("ovf_pcw", a_pc_write, 1);
      chk("ovf_aluop", a_alu_op, 1);
      chk("ovf_rw", a_reg_write, 0);
      step();
      chk("ovf_back_fetch", a_state, 0);

      // slt: overflow never traps
      funct = 6'h2a;
      step(); step();
      chk("slt_op", a_alu_op, 4);
      overflow = 1'b1;
      step();
      overflow = 1'b0;
      chk("slt_no_trap", a_state, 3);
      step();

      // bne / beq
      opcode = 6'h05;
      step(); step();
      chk("bne_state", a_state, 10);
      zero = 1'b0; #1;
      chk("bne_z0_pcw", a_pc_write, 1);
      chk("bne_pcsrc", a_pc_src, 1);
      zero = 1'b1; #1;
      chk("bne_z1_pcw", a_pc_write, 0);
      step();
      chk("bne_back_fetch", a_state, 0);
      zero = 1'b0;
      opcode = 6'h04;
      step(); step();
      chk("beq_z0_pcw", a_pc_write, 0);
      zero = 1'b1; #1;
      chk("beq_z1_pcw", a_pc_write, 1);
      zero = 1'b0;
      step();

      // jal
      opcode = 6'h03;
      step(); step();
      chk("jal_state", a_state, 11);
      chk("jal_pcsrc", a_pc_src, 2);
      chk("jal_pcw", a_pc_write, 1);
      chk("jal_rw", a_reg_write, 1);
      chk("jal_dst", a_reg_dst, 2);
      chk("jal_m2r", a_mem_to_reg, 4);
      step();

      // div with divide-by-zero; early md_done ignored
      opcode = 6'h00; funct = 6'h1a;
      step(); step();
      chk("div_start_state", a_state, 14);
      chk("div_start", a_md_start, 1);
      chk("div_mdop", a_md_op, 1);
      md_done = 1'b1;
      step();
      md_done = 1'b0;
      chk("div_wait_state", a_state, 15);
      chk("div_start_pulse", a_md_start, 0);
      chk("div_wait_mdop", a_md_op, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("div_wait_hold", a_state, 15);
         chk("div_wait_nostart", a_md_start, 0);
      end
      md_done = 1'b1; md_div0 = 1'b1; #1;
      chk("div0_no_hilo", a_hilo_write, 0);
      step();
      md_done = 1'b0; md_div0 = 1'b0;
      chk("div0_exc_state", a_state, 18);
      chk("div0_cause", a_cause, 3);
      chk("div0_hilo", a_hilo_write, 0);
      step();

      // div completing normally
      step(); step(); step();
      step();
      md_done = 1'b1;
      step();
      md_done = 1'b0;
      chk("div_ok_state", a_state, 16);
      chk("div_ok_hilo", a_hilo_write, 1);
      step();
      chk("div_ok_fetch", a_state, 0);
      chk("div_ok_hilo_off", a_hilo_write, 0);

      // mult then mflo
      funct = 6'h18;
      step(); step();
      chk("mult_mdop", a_md_op, 0);
      step();
      md_done = 1'b1;
      step();
      md_done = 1'b0;
      step();
      funct = 6'h12;
      step(); step();
      chk("mflo_state", a_state, 17);
      chk("mflo_rw", a_reg_write, 1);
      chk("mflo_m2r", a_mem_to_reg, 3);
      step();

      // invalid opcode
      opcode = 6'h3f;
      step(); step();
      chk("inv_state", a_state, 18);
      chk("inv_cause", a_cause, 1);
      step();
      chk("inv_back_fetch", a_state, 0);
      rst1 = 1'b1;

      // lw, MEM_LAT=3
      opcode = 6'h23; funct = 6'h00;
      rst3 = 1'b0; #1;
      chk("lw_c1_irw", b_ir_write, 0);
      n = 0;
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) step();
         n += int'(b_iord);
         if (c == 3) chk("lw_c3_irw", b_ir_write, 1);
         if (c == 9) begin
            chk("lw_c9_state", b_state, 8);
            chk("lw_c9_rw", b_reg_write, 1);
            chk("lw_c9_m2r", b_mem_to_reg, 1);
            chk("lw_c9_dst", b_reg_dst, 0);
         end else begin
            chk("lw_no_rw", b_reg_write, 0);
         end
      end
      chk("lw_iord_cycles", n, 3);
      step();
      chk("lw_back_fetch", b_state, 0);

      // sw, MEM_LAT=3
      opcode = 6'h2b;
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) step();
         n += int'(b_mem_wr);
      end
      chk("sw_c8_state", b_state, 9);
      chk("sw_memwr_cycles", n, 3);
      step();
      chk("sw_back_fetch", b_state, 0);

      // add with overflow, EXC_EN=0
      opcode = 6'h00; funct = 6'h20;
      repeat (4) step();
      chk("noexc_ex_state", b_state, 2);
      overflow = 1'b1;
      step();
      overflow = 1'b0;
      chk("noexc_wb_state", b_state, 3);
      chk("noexc_rw", b_reg_write, 1);
      step();

      // reset during LW_MEM
      opcode = 6'h23;
      repeat (5) step();
      chk("rstmid_lwmem", b_state, 7);
      rst3 = 1'b1; #1;
      chk("rstmid_iord_off", b_iord, 0);
      step();
      chk("rstmid_fetch", b_state, 0);
      chk("rstmid_rw", b_reg_write, 0);
      rst3 = 1'b0; #1;
      for (int c = 1; c <= 4; c++) begin
         chk("rstmid_no_rw", b_reg_write, 0);
         step();
      end
      chk("rstmid_restart", b_state, 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
